// File: rtl/pool_writer_pkg.sv
// Shared types and default widths for the pool_writer block.
// Holds the FSM state encoding, the pooling mode and the parameter defaults.
package pool_writer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_ROW_PIXELS = 8;
  localparam int DEFAULT_BASE_ADDR  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef enum logic {
    MODE_PASS = 1'b0,
    MODE_POOL = 1'b1
  } mode_t;

endpackage

// File: rtl/pool_writer_max2.sv
// Combinational signed maximum of two operands.
// Used for both the horizontal pair compare and the vertical window compare.
module pool_max2
  import pool_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);

  assign y = (a > b) ? a : b;

endmodule

// File: rtl/pool_writer.sv
// Writes a convolution output stream into RAM, either unchanged or 2x2 max-pooled.
// Even rows fill a half-row line buffer with pair maxima; odd rows complete each window.
module pool_writer
  import pool_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ROW_PIXELS = DEFAULT_ROW_PIXELS,
  parameter int BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         conv_start,
  input  logic                         conv_done,
  input  logic                         pool_en,
  input  logic                         pix_valid,
  input  logic signed [DATA_WIDTH-1:0] pix_data,
  output logic                         wr_en,
  output logic        [ADDR_WIDTH-1:0] wr_addr,
  output logic signed [DATA_WIDTH-1:0] wr_data,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam int HALF  = ROW_PIXELS / 2;
  localparam int COL_W = (ROW_PIXELS > 2) ? $clog2(ROW_PIXELS) : 1;
  localparam int K_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [COL_W-1:0]      LAST_COL = COL_W'(ROW_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  state_t                         state;
  mode_t                          mode;
  logic        [COL_W-1:0]        col;
  logic                           odd_row;
  logic signed [DATA_WIDTH-1:0]   first_pix;
  logic signed [DATA_WIDTH-1:0]   line_buf [HALF];

  logic                           accept;
  logic                           lb_we;
  logic        [K_W-1:0]          k;
  logic signed [DATA_WIDTH-1:0]   pair_max;
  logic signed [DATA_WIDTH-1:0]   vert_max;

  // A restart takes priority over any pixel presented in the same cycle.
  assign accept = (state == ST_RUN) && pix_valid && !conv_start;
  assign k      = K_W'(col >> 1);
  assign lb_we  = accept && (mode == MODE_POOL) && col[0] && !odd_row;

  pool_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_pair (
    .a (first_pix),
    .b (pix_data),
    .y (pair_max)
  );

  pool_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_vert (
    .a (pair_max),
    .b (line_buf[k]),
    .y (vert_max)
  );

  always_ff @(posedge clock) begin
    if (lb_we) line_buf[k] <= pair_max;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode       <= MODE_PASS;
      col        <= '0;
      odd_row    <= 1'b0;
      first_pix  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= BASE;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      // wr_addr names the current write; it steps once that write has been presented.
      if (wr_en) begin
        wr_addr <= wr_addr + ADDR_WIDTH'(1);
        if (&wr_addr) overflow <= 1'b1;
      end
      if (conv_start) begin
        state    <= ST_RUN;
        busy     <= 1'b1;
        mode     <= mode_t'(pool_en);
        wr_addr  <= BASE;
        col      <= '0;
        odd_row  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            if (pix_valid) begin
              if (mode == MODE_PASS) begin
                wr_en   <= 1'b1;
                wr_data <= pix_data;
              end else begin
                if (!col[0]) begin
                  first_pix <= pix_data;
                end else if (odd_row) begin
                  wr_en   <= 1'b1;
                  wr_data <= vert_max;
                end
                if (col == LAST_COL) begin
                  col     <= '0;
                  odd_row <= ~odd_row;
                end else begin
                  col <= col + COL_W'(1);
                end
              end
            end
            if (conv_done) state <= ST_FLUSH;
          end
          ST_FLUSH: begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pool_writer.sv
// Self-checking bench for pool_writer: vector table plus a write scoreboard.
// A second instance with a 3-bit address space exercises wrap and overflow.
module tb_pool_writer;

  localparam int DW = 16;
  localparam int AW = 10;

  logic clock = 1'b0;
  logic reset, conv_start, conv_done, pool_en, pix_valid;
  logic signed [DW-1:0] pix_data;

  logic                 wr_en, busy, frame_done, overflow;
  logic        [AW-1:0] wr_addr;
  logic signed [DW-1:0] wr_data;

  logic                 ov_wr_en, ov_busy, ov_frame_done, ov_overflow;
  logic        [2:0]    ov_wr_addr;
  logic signed [DW-1:0] ov_wr_data;

  pool_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_PIXELS(4), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .conv_start(conv_start), .conv_done(conv_done),
    .pool_en(pool_en), .pix_valid(pix_valid), .pix_data(pix_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  pool_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .ROW_PIXELS(4), .BASE_ADDR(6)) dut_ov (
    .clock(clock), .reset(reset), .conv_start(conv_start), .conv_done(conv_done),
    .pool_en(pool_en), .pix_valid(pix_valid), .pix_data(pix_data),
    .wr_en(ov_wr_en), .wr_addr(ov_wr_addr), .wr_data(ov_wr_data),
    .busy(ov_busy), .frame_done(ov_frame_done), .overflow(ov_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    string                name;
    logic                 start, done, pool, valid;
    logic signed [DW-1:0] pix;
    logic                 exp_wr;
    logic        [AW-1:0] exp_addr;
    logic signed [DW-1:0] exp_data;
    logic                 exp_busy, exp_fdone;
  } vec_t;

  typedef struct {
    logic        [AW-1:0] addr;
    logic signed [DW-1:0] data;
    int                   due;
  } wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string name, logic start, logic done, logic pool, logic valid,
                              int pix, logic exp_wr, int addr, int data, logic b, logic fd);
    vec_t v;
    v.name = name; v.start = start; v.done = done; v.pool = pool; v.valid = valid;
    v.pix = DW'(pix); v.exp_wr = exp_wr; v.exp_addr = AW'(addr); v.exp_data = DW'(data);
    v.exp_busy = b; v.exp_fdone = fd;
    return v;
  endfunction

  function automatic void add(string name, logic start, logic done, logic pool, logic valid,
                              int pix, logic exp_wr, int addr, int data, logic b, logic fd);
    vecs.push_back(mk(name, start, done, pool, valid, pix, exp_wr, addr, data, b, fd));
  endfunction

  // Drive one cycle of inputs, queue its expected write, then check status after the edge.
  task automatic applyStimulus(input vec_t v);
    wr_t w;
    conv_start = v.start;
    conv_done  = v.done;
    pool_en    = v.pool;
    pix_valid  = v.valid;
    pix_data   = v.pix;
    if (v.exp_wr) begin
      w.addr = v.exp_addr;
      w.data = v.exp_data;
      w.due  = cyc + 1;
      exp_q.push_back(w);
    end
    @(posedge clock);
    #1;
    checkOutput({v.name, " busy"}, 32'(busy), 32'(v.exp_busy));
    checkOutput({v.name, " frame_done"}, 32'(frame_done), 32'(v.exp_fdone));
  endtask

  // Every observed write must match the oldest expectation, in the right cycle.
  always @(posedge clock) begin
    wr_t w;
    cyc = cyc + 1;
    #2;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected write: addr %0h data %0h at cycle %0d", wr_addr, wr_data, cyc);
      end else begin
        w = exp_q.pop_front();
        checkOutput("write addr", 32'(wr_addr), 32'(w.addr));
        checkOutput("write data", 32'(wr_data), 32'(w.data));
        checkOutput("write cycle", 32'(cyc), 32'(w.due));
      end
    end
  end

  initial begin
    reset = 1'b1; conv_start = 1'b0; conv_done = 1'b0; pool_en = 1'b0;
    pix_valid = 1'b0; pix_data = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset wr_en", 32'(wr_en), 32'd0);
    checkOutput("reset wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset wr_data", 32'(wr_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset ov wr_addr", 32'(ov_wr_addr), 32'd6);
    reset = 1'b0;

    // Pass-through frame, then idle-state pixel and conv_done that must be ignored
    add("pt_start", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 6; i++) add("pt_pix", 0, 0, 0, 1, i, 1, i - 1, i, 1, 0);
    add("pt_done",   0, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    add("pt_flush",  0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    add("pt_after",  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add("idle_pix",  0, 0, 0, 1, 99, 0, 0, 0, 0, 0);
    add("idle_done", 0, 1, 0, 0, 0,  0, 0, 0, 0, 0);

    // Pool frame; pool_en drops mid-frame and must not change the mode
    add("pl_start", 1, 0, 1, 0, 0,   0, 0, 0, 1, 0);
    add("pl_r1",    0, 0, 1, 1, 1,   0, 0, 0, 1, 0);
    add("pl_r1",    0, 0, 1, 1, 5,   0, 0, 0, 1, 0);
    add("pl_r1",    0, 0, 1, 1, -3,  0, 0, 0, 1, 0);
    add("pl_r1",    0, 0, 1, 1, 2,   0, 0, 0, 1, 0);
    add("pl_r2",    0, 0, 1, 1, 4,   0, 0, 0, 1, 0);
    add("pl_r2",    0, 0, 1, 1, 0,   1, 0, 5, 1, 0);
    add("pl_r2",    0, 0, 1, 1, -7,  0, 0, 0, 1, 0);
    add("pl_r2",    0, 0, 1, 1, -1,  1, 1, 2, 1, 0);
    add("pl_r3",    0, 0, 0, 1, 10,  0, 0, 0, 1, 0);
    add("pl_r3",    0, 0, 0, 1, -20, 0, 0, 0, 1, 0);
    add("pl_gap",   0, 0, 0, 0, 55,  0, 0, 0, 1, 0);
    add("pl_r3",    0, 0, 0, 1, 7,   0, 0, 0, 1, 0);
    add("pl_r3",    0, 0, 0, 1, 7,   0, 0, 0, 1, 0);
    add("pl_r4",    0, 0, 0, 1, 3,   0, 0, 0, 1, 0);
    add("pl_r4",    0, 0, 0, 1, 11,  1, 2, 11, 1, 0);
    add("pl_r4",    0, 0, 0, 1, -8,  0, 0, 0, 1, 0);
    add("pl_r4dn",  0, 1, 0, 1, 6,   1, 3, 7, 1, 0);
    add("pl_flush", 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);

    // All-negative windows, ending with a discarded partial window
    add("sg_start", 1, 0, 1, 0, 0,   0, 0, 0, 1, 0);
    add("sg_r1",    0, 0, 1, 1, -2,  0, 0, 0, 1, 0);
    add("sg_r1",    0, 0, 1, 1, -9,  0, 0, 0, 1, 0);
    add("sg_r1",    0, 0, 1, 1, -4,  0, 0, 0, 1, 0);
    add("sg_r1",    0, 0, 1, 1, -6,  0, 0, 0, 1, 0);
    add("sg_r2",    0, 0, 1, 1, -5,  0, 0, 0, 1, 0);
    add("sg_r2",    0, 0, 1, 1, -1,  1, 0, -1, 1, 0);
    add("sg_r2",    0, 0, 1, 1, -8,  0, 0, 0, 1, 0);
    add("sg_r2",    0, 0, 1, 1, -3,  1, 1, -3, 1, 0);
    for (int i = 0; i < 4; i++) add("sg_r3", 0, 0, 1, 1, -7, 0, 0, 0, 1, 0);
    add("sg_r4dn",  0, 1, 1, 1, -9,  0, 0, 0, 1, 0);
    add("sg_flush", 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);

    // conv_done after one and a half rows
    add("hf_start", 1, 0, 1, 0, 0,   0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) add("hf_r1", 0, 0, 1, 1, i, 0, 0, 0, 1, 0);
    add("hf_r2",    0, 0, 1, 1, 5,   0, 0, 0, 1, 0);
    add("hf_r2dn",  0, 1, 1, 1, 6,   1, 0, 6, 1, 0);
    add("hf_flush", 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);

    // Restart mid-frame with start+done together and a new mode
    add("ab_start", 1, 0, 1, 0, 0,   0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) add("ab_r1", 0, 0, 1, 1, i, 0, 0, 0, 1, 0);
    add("ab_r2",    0, 0, 1, 1, 9,   0, 0, 0, 1, 0);
    add("ab_restart", 1, 1, 0, 1, 77, 0, 0, 0, 1, 0);
    add("ab_pix",   0, 0, 1, 1, 8,   1, 0, 8, 1, 0);
    add("ab_pix",   0, 0, 1, 1, 9,   1, 1, 9, 1, 0);
    add("ab_done",  0, 1, 1, 0, 0,   0, 0, 0, 1, 0);
    add("ab_flush", 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);
    add("ab_after", 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
    checkOutput("main overflow clear", 32'(overflow), 32'd0);

    // Address wrap on the 3-bit instance starting at 6
    applyStimulus(mk("ov_start", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    checkOutput("ov busy", 32'(ov_busy), 32'd1);
    checkOutput("ov overflow start", 32'(ov_overflow), 32'd0);
    applyStimulus(mk("ov_pix", 0, 0, 0, 1, 1, 1, 0, 1, 1, 0));
    checkOutput("ov wr_en 1", 32'(ov_wr_en), 32'd1);
    checkOutput("ov addr 1", 32'(ov_wr_addr), 32'd6);
    checkOutput("ov data 1", 32'(ov_wr_data), 32'd1);
    applyStimulus(mk("ov_pix", 0, 0, 0, 1, 2, 1, 1, 2, 1, 0));
    checkOutput("ov addr 2", 32'(ov_wr_addr), 32'd7);
    checkOutput("ov overflow early", 32'(ov_overflow), 32'd0);
    applyStimulus(mk("ov_pix", 0, 0, 0, 1, 3, 1, 2, 3, 1, 0));
    checkOutput("ov addr 3", 32'(ov_wr_addr), 32'd0);
    checkOutput("ov overflow set", 32'(ov_overflow), 32'd1);
    applyStimulus(mk("ov_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    checkOutput("ov wr_en idle", 32'(ov_wr_en), 32'd0);
    checkOutput("ov addr after", 32'(ov_wr_addr), 32'd1);
    checkOutput("ov data hold", 32'(ov_wr_data), 32'd3);
    checkOutput("ov overflow sticky", 32'(ov_overflow), 32'd1);
    checkOutput("ov frame_done low", 32'(ov_frame_done), 32'd0);
    applyStimulus(mk("ov_restart", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    checkOutput("ov overflow cleared", 32'(ov_overflow), 32'd0);
    checkOutput("ov addr base", 32'(ov_wr_addr), 32'd6);
    applyStimulus(mk("ov_done", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(mk("ov_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Reset in the middle of a frame aborts without further writes
    applyStimulus(mk("rs_start", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(mk("rs_pix", 0, 0, 0, 1, 5, 1, 0, 5, 1, 0));
    reset = 1'b1; pix_valid = 1'b1; pix_data = 16'sd6;
    @(posedge clock);
    #1;
    checkOutput("rs wr_en", 32'(wr_en), 32'd0);
    checkOutput("rs busy", 32'(busy), 32'd0);
    checkOutput("rs wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rs wr_data", 32'(wr_data), 32'd0);
    reset = 1'b0;

    conv_start = 1'b0; conv_done = 1'b0; pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(posedge clock);
    #3;
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool_writer.md
POOL_WRITER -- requirements
Module: pool_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set pixel and write-data width (two's-complement signed).
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set write-address width.
REQ-003 Parameter ROW_PIXELS, default 8, SHALL set conv output row length; even, >=2.
REQ-004 Parameter BASE_ADDR, default 0, SHALL set the first write address of every frame.
REQ-005 Ports SHALL be: clock in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-006 Ports SHALL be: conv_start in 1, frame start pulse; conv_done in 1, frame end pulse; pool_en in 1, mode select, 1=2x2 max pool, 0=pass-through.
REQ-007 Ports SHALL be: pix_valid in 1, pixel strobe; pix_data in DATA_WIDTH, conv pixel.
REQ-008 Ports SHALL be: wr_en out 1; wr_addr out ADDR_WIDTH; wr_data out DATA_WIDTH; RAM write port.
REQ-009 Ports SHALL be: busy out 1, frame active; frame_done out 1, one-cycle pulse; overflow out 1, sticky address wrap flag.

Function
REQ-010 FSM SHALL have states IDLE, RUN, FLUSH; reset state IDLE.
REQ-011 IDLE -> RUN on conv_start: latch pool_en into mode, wr_addr<=BASE_ADDR, column/row counters<=0, overflow<=0.
REQ-012 pool_en changes outside the conv_start cycle SHALL have no effect.
REQ-013 busy SHALL be 1 in RUN and FLUSH, 0 in IDLE; pix_valid in IDLE SHALL be ignored.
REQ-014 Pass-through: each accepted pixel SHALL produce wr_en=1 with wr_data=pix_data exactly one cycle later (latency 1).
REQ-015 Pool mode: column counter 0..ROW_PIXELS-1 and row-parity bit SHALL advance per accepted pixel; column wraps to 0 and toggles parity after ROW_PIXELS-1.
REQ-016 Pool even row: signed max of pixel pair (col 2k, 2k+1) SHALL be stored in internal line buffer entry k (ROW_PIXELS/2 entries).
REQ-017 Pool odd row: on pixel col 2k+1, signed max of pair and buffer entry k SHALL be written, wr_en=1 one cycle after that pixel.
REQ-018 Pool mode SHALL emit exactly ROW_PIXELS/2 writes per two input rows.
REQ-019 After every write wr_addr SHALL increment by 1; all-ones wraps to 0 and sets overflow, held until next conv_start.
REQ-020 wr_en SHALL be 0 in every cycle not defined above; wr_addr/wr_data SHALL hold between writes.
REQ-021 conv_done in RUN: a pixel valid in the same cycle SHALL be accepted; FSM -> FLUSH; pending write emitted; FLUSH -> IDLE next cycle with frame_done=1 for one cycle.
REQ-022 Incomplete pool windows at conv_done SHALL be discarded, no write.
REQ-023 conv_start in RUN or FLUSH SHALL restart the frame per REQ-011; pixel in that cycle ignored; partial windows discarded; no frame_done for the aborted frame.
REQ-024 conv_start and conv_done in the same cycle SHALL be treated as conv_start only.
REQ-025 conv_done in IDLE SHALL be ignored.

Reset
REQ-026 reset SHALL force: state IDLE, wr_en 0, wr_addr BASE_ADDR, wr_data 0, busy 0, frame_done 0, overflow 0, counters 0, mode 0.
REQ-027 Line buffer contents need not be cleared; reset mid-frame SHALL abort with no further writes.

Structure
REQ-028 Package pool_writer_pkg SHALL hold the FSM state type, mode type and default width constants.
REQ-029 Sub-module pool_max2 (combinational signed max of two DATA_WIDTH operands) SHALL be instantiated for pair and vertical compares.

Verification
REQ-030 Pass-through, ROW_PIXELS=4: conv_start, pixels 1..6 back-to-back, conv_done -> writes 1..6 at addr 0..5, each 1 cycle after input; frame_done once.
REQ-031 Pool, ROW_PIXELS=4: rows [1,5,-3,2],[4,0,-7,-1] -> writes 5@0, 2@1; rows 3-4 continue at addr 2.
REQ-032 Signed: pool pair -2,-9 over -5,-1 -> write -1; all-negative window never yields 0.
REQ-033 ADDR_WIDTH=3, BASE_ADDR=6, pass-through, 3 pixels -> addrs 6,7,0; overflow=1 after third write, cleared by next conv_start.
REQ-034 Pool mid-window conv_done after 1.5 rows -> only completed writes emitted, frame_done pulse, busy falls next cycle.
REQ-035 conv_start mid-frame with pool_en toggled -> addr back to BASE_ADDR, new mode used, no frame_done for aborted frame.
